// File: rtl/dlv_pipe_if.sv
// Bus bundle for dlv_pipe: stimulus (en/clr/d/d_vld/dly) and tap outputs (q/q_vld/primed/fill).
interface dlv_pipe_if #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned DW = $clog2(DEPTH + 1);

    logic             en;
    logic             clr;
    logic [WIDTH-1:0] d;
    logic             d_vld;
    logic [DW-1:0]    dly;
    logic [WIDTH-1:0] q;
    logic             q_vld;
    logic             primed;
    logic [DW-1:0]    fill;

    // Driver side: supplies data and tap select, observes the tap
    modport master (
        output en, clr, d, d_vld, dly,
        input  q, q_vld, primed, fill
    );

    // Pipeline side
    modport slave (
        input  en, clr, d, d_vld, dly,
        output q, q_vld, primed, fill
    );
endinterface

// File: rtl/dlv_pipe.sv
// dlv_pipe: enable-gated delay line with a run-time selectable tap, valid tags
// and a saturating fill counter used to report when the selected tap is primed.
// Optional macro DLV_PIPE_BYPASS_EN: dly=0 becomes a zero-delay combinational bypass.
module dlv_pipe #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    dlv_pipe_if.slave bus
);
    localparam int unsigned DW = $clog2(DEPTH + 1);

    // Element 0 is stage 1 (nearest d), element DEPTH-1 is stage DEPTH
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [DW-1:0]    fill_q;
    logic [DW-1:0]    fill_d;

    logic [DW-1:0]    tap_c;
    logic [WIDTH-1:0] q_c;
    logic             q_vld_c;
    logic             primed_c;

    // Next state: flush beats shift; shift only on en; hold otherwise
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        fill_d = fill_q;
        if (bus.clr) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_d[k] = '0;
            end
            vld_d  = '0;
            fill_d = '0;
        end else if (bus.en) begin
            data_d[0] = bus.d;
            for (int k = 1; k < DEPTH; k++) begin
                data_d[k] = data_q[k-1];
            end
            vld_d = {vld_q[DEPTH-2:0], bus.d_vld};
            if (fill_q != DW'(DEPTH)) begin
                fill_d = fill_q + DW'(1);
            end
        end
    end

    // Stage and fill registers; reset clears everything immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
            vld_q  <= '0;
            fill_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= data_d[k];
            end
            vld_q  <= vld_d;
            fill_q <= fill_d;
        end
    end

    // Clamp the requested delay into 1..DEPTH
    always_comb begin
        tap_c = bus.dly;
        if (bus.dly == '0) begin
            tap_c = DW'(1);
        end else if (bus.dly > DW'(DEPTH)) begin
            tap_c = DW'(DEPTH);
        end
    end

    // Tap mux and primed flag; a one-hot compare keeps the result X-free for any dly
    always_comb begin
        q_c     = '0;
        q_vld_c = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (tap_c == DW'(k + 1)) begin
                q_c     = data_q[k];
                q_vld_c = vld_q[k];
            end
        end
        primed_c = (fill_q >= tap_c);
`ifdef DLV_PIPE_BYPASS_EN
        if (bus.dly == '0) begin
            q_c      = rst_n ? bus.d : '0;
            q_vld_c  = rst_n & bus.d_vld;
            primed_c = rst_n;
        end
`endif
    end

    assign bus.q      = q_c;
    assign bus.q_vld  = q_vld_c;
    assign bus.primed = primed_c;
    assign bus.fill   = fill_q;
endmodule
